// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and constants for the counter library
package counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable down-counter with terminal-count pulse
// and one-shot / auto-reload modes
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] reload_q, reload_nxt;
  logic             tc_nxt;

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_q;
    tc_nxt     = 1'b0;
    if (load) begin
      count_nxt  = load_val;
      reload_nxt = load_val;
      state_nxt  = (load_val != '0) ? RUN : IDLE;
    end else if (state == RUN && en) begin
      if (count > ONE) begin
        count_nxt = count - ONE;
      end else if (count == ONE) begin
        tc_nxt = 1'b1;
        if (mode == MODE_RELOAD) begin
          count_nxt = reload_q;
        end else begin
          count_nxt = '0;
          state_nxt = IDLE;
        end
      end else begin
        // RUN with count 0 is unreachable; fall back to IDLE rather than wrap
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      reload_q <= '0;
      tc       <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      reload_q <= reload_nxt;
      tc       <= tc_nxt;
    end
  end

  assign zero = (count == '0);
  assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - randomized and directed bench for
// down_counter_timer against a behavioural model
module tb_down_counter_timer;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       mode;
  logic [3:0] count;
  logic       zero;
  logic       tc;
  logic       busy;

  int tests = 0;
  int fails = 0;

  // model state: plain integers describing the timer's behaviour
  int  m_count  = 0;
  int  m_reload = 0;
  bit  m_run    = 0;
  bit  m_tc     = 0;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .mode     (mode),
    .count    (count),
    .zero     (zero),
    .tc       (tc),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit l, input int lv, input bit e, input bit m);
    if (r) begin
      m_count = 0; m_reload = 0; m_run = 0; m_tc = 0;
    end else if (l) begin
      m_count = lv; m_reload = lv; m_run = (lv != 0); m_tc = 0;
    end else if (m_run && e) begin
      if (m_count > 1) begin
        m_count = m_count - 1; m_tc = 0;
      end else begin
        m_tc = 1;
        if (m) m_count = m_reload;
        else begin m_count = 0; m_run = 0; end
      end
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic step(input bit r, input bit l, input int lv, input bit e, input bit m);
    rst = r; load = l; load_val = lv[3:0]; en = e; mode = m;
    @(posedge clk);
    model_edge(r, l, lv, e, m);
    #1;
    check("count", int'(count), m_count);
    check("zero",  int'(zero),  int'(m_count == 0));
    check("tc",    int'(tc),    int'(m_tc));
    check("busy",  int'(busy),  int'(m_run));
  endtask

  initial begin
    int exp_os_count[5] = '{3, 2, 1, 0, 0};
    int exp_os_tc[5]    = '{0, 0, 0, 1, 0};
    int exp_en_count[5] = '{5, 4, 4, 4, 3};
    int en_pat[5]       = '{1, 1, 0, 0, 1};

    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; mode = 1'b0;

    step(1, 0, 0, 0, 0);
    check("reset_zero", int'(zero), 1);
    check("reset_busy", int'(busy), 0);

    // one-shot from 3
    for (int i = 0; i < 5; i++) begin
      step(0, (i == 0), 3, 1, 0);
      check("oneshot_count", int'(count), exp_os_count[i]);
      check("oneshot_tc", int'(tc), exp_os_tc[i]);
    end

    // auto-reload period 2, then period 1
    step(0, 1, 2, 1, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 1);
      check("reload2_tc", int'(tc), int'(count == 4'd2));
    end
    step(0, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 1);
      check("reload1_tc", int'(tc), 1);
    end

    // enable gating
    for (int i = 0; i < 5; i++) begin
      step(0, (i == 0), 5, en_pat[i][0], 0);
      check("engate_count", int'(count), exp_en_count[i]);
      check("engate_busy", int'(busy), 1);
    end

    // load colliding with terminal event
    step(0, 1, 2, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 9, 1, 0);
    check("collide_count", int'(count), 9);
    check("collide_tc", int'(tc), 0);

    // load of zero stays idle
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    check("load0_busy", int'(busy), 0);

    // reset mid-run beats load
    step(0, 1, 15, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);
    step(1, 1, 7, 1, 1);
    check("rst_count", int'(count), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
    check("rst_idle_busy", int'(busy), 0);

    // randomized traffic
    begin
      bit cur_mode = 1'b0;
      for (int i = 0; i < 600; i++) begin
        bit r  = ($urandom_range(0, 59) == 0);
        bit l  = ($urandom_range(0, 9) == 0);
        int lv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 15);
        bit e  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 19) == 0) cur_mode = ~cur_mode;
        step(r, l, lv, e, cur_mode);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Synchronous, loadable down-counter with terminal-count detection and selectable one-shot or auto-reload behaviour. It is the counting-down companion to the ripple up-counter in the sequential/counter library. Its intended users are interval timers, delay generators and divide-by-N clock enables. All flops share one clock, so the block has no ripple delay and its outputs are safe to use as synchronous enables elsewhere.

## Interface
- WIDTH, 4, counter and reload width in bits (≥2)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- load  input  1  load load_val into count and reload register
- load_val  input  WIDTH  value captured on load
- en  input  1  count enable; decrement only while high
- mode  input  1  0 = one-shot, 1 = auto-reload; sampled every cycle
- count  output  WIDTH  current counter value
- zero  output  1  combinational, count == 0
- tc  output  1  terminal-count pulse, registered, one cycle wide
- busy  output  1  high while state is RUN

## Operation
- State machine has two states.
  - IDLE: counter stopped; busy = 0.
  - RUN: counter active; busy = 1.
- Reset (rst = 1 at an edge) gives count = 0, reload register = 0, state IDLE and tc = 0, so zero = 1 and busy = 0. rst overrides every other input.
- Priority at each edge: rst > load > en.
- load = 1, any state:
  - count ← load_val and reload ← load_val.
  - Next state is RUN if load_val ≠ 0, otherwise IDLE.
  - tc = 0 that cycle.
- IDLE: en is ignored; count holds.
- RUN, en = 0: count holds; tc = 0.
- RUN, en = 1, count > 1: count ← count − 1; tc = 0.
- RUN, en = 1, count == 1, terminal event (tc = 1 in the following cycle):
  - mode = 0: count ← 0; state → IDLE.
  - mode = 1: count ← reload; state stays RUN.
- Width and arithmetic:
  - Unsigned modulo-2^WIDTH arithmetic.
  - count never decrements below 0; there is no underflow wrap.
  - load_val = 2^WIDTH − 1 is legal.
- Auto-reload period is exactly reload cycles of en = 1. The count sequence is reload … 1, reload … 1; the value 0 is never shown.

## Timing
- Latency from load to count = load_val and busy updated: 1 edge.
- Decrement latency: 1 edge per enabled cycle.
- tc is asserted in the same cycle count first shows its post-terminal value (0 or reload).
  - Deasserted on the next edge unless a new terminal event occurs there.
  - With reload = 1 in auto-reload and en held high, tc stays high continuously.
- In one-shot, busy falls and zero rises in the same cycle as tc.
- If load coincides with a terminal event, load wins: count = load_val and tc = 0.
- rst mid-run: the next cycle shows count = 0, tc = 0 and busy = 0, with no tc pulse emitted.
- Changing mode mid-run affects only the next terminal event.

## Structure
- Shared package counter_pkg holds the state typedef (IDLE, RUN) and the mode constants MODE_ONESHOT = 0 and MODE_RELOAD = 1.
- Single module with no sub-module.
  - Next-state/next-count logic is one combinational process.
  - Registers (count, reload, state, tc) are one clocked process.

## Test plan
- Reset, then load = 1 with load_val = 3, mode = 0, en = 1:
  - count 3, 2, 1, 0 on successive cycles.
  - tc = 1 only in the cycle count = 0; busy and zero switch in that same cycle.
  - count holds 0 afterwards.
- load_val = 2, mode = 1, en = 1 for 8 cycles: count 2, 1, 2, 1, 2, 1 …, with tc high in each cycle count returns to 2. Then load_val = 1: tc stays high every cycle.
- load_val = 5, en toggled 1, 0, 0, 1: count 5, 4, 4, 4, 3; tc never asserted; busy = 1 throughout.
- Count at 1 with en = 1, and load = 1 with load_val = 9 in the same cycle: next count = 9, tc = 0, busy = 1.
- load_val = 0: count = 0, busy = 0, zero = 1, tc = 0. A following en = 1 leaves all outputs unchanged.
- load_val = 15 (WIDTH = 4), run 6 cycles, then assert rst with load = 1 in the same cycle:
  - Next cycle count = 0, busy = 0, tc = 0; the reload register is cleared.
  - Asserting en afterwards stays IDLE.
